ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 32, address width; equals the AHB bus width.
REQ-002 Parameter RR_EN, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with port 0 winning.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_i[1:0]  input  2  per-port request; port 0 = instruction fetch, port 1 = load/store.
REQ-006 we_i[1:0]  input  2  per-port write enable (1 = write word, 0 = read word).
REQ-007 addr0_i, addr1_i  input  AW each  per-port word address; bits [1:0] are ignored.
REQ-008 wdata0_i, wdata1_i  input  32 each  per-port write data.
REQ-009 wstrb0_i, wstrb1_i  input  4 each  per-port byte strobes; bit n qualifies byte n.
REQ-010 gnt_o[1:0]  output  2  one-hot grant; the request is accepted in the cycle gnt is high.
REQ-011 rvalid_o[1:0]  output  2  one-cycle completion pulse for the granted port.
REQ-012 rdata_o  output  32  assembled read data; valid only while rvalid_o is high.
REQ-013 ram_en_o, ram_we_o  output  1 each  RAM enable and write strobe.
REQ-014 ram_addr_o  output  AW  RAM byte address.
REQ-015 ram_wdata_o  output  8  RAM write byte.
REQ-016 ram_rdata_i  input  8  RAM read byte; combinational, valid in the same cycle as the address.

Function
REQ-017 State machine: IDLE -> BEAT (4 cycles, beat counter 0..3) -> RESP -> IDLE. There are no other states.
REQ-018 gnt_o is combinational and may be nonzero only in IDLE.
- gnt_o[p] = 1 when req_i[p] = 1 and port p wins arbitration.
- Port p must hold req, we, addr, wdata and wstrb stable until it sees gnt.
REQ-019 When both ports request in IDLE:
- RR_EN = 1: the port not granted last wins.
- After reset, the last-granted pointer selects port 0 as the winner.
- RR_EN = 0: port 0 always wins.
REQ-020 The last-granted pointer updates only on an actual grant; a lone requester is always granted.
REQ-021 On grant, the block latches port id, we, addr[AW-1:2], wdata and wstrb, then moves to BEAT with beat = 0.
REQ-022 In each BEAT cycle, ram_addr_o = {latched addr[AW-1:2], beat[1:0]} (little-endian: beat 0 = bits [7:0]).
REQ-023 Read beat: ram_en_o = 1 and ram_we_o = 0; ram_rdata_i is captured into byte[beat] at the clock edge.
REQ-024 Write beat with strb[beat] = 1: ram_en_o = 1, ram_we_o = 1, ram_wdata_o = wdata byte[beat].
REQ-025 Write beat with strb[beat] = 0: ram_en_o = 0 and ram_we_o = 0; the beat still takes one cycle, so latency is fixed.
REQ-026 Read requests ignore wstrb; all 4 bytes are always read.
REQ-027 In RESP, rvalid_o[port] = 1 for exactly one cycle.
- Read: rdata_o = assembled word.
- Write: rdata_o = 0.
REQ-028 Latency: grant at cycle T -> beats at T+1..T+4 -> rvalid at T+5. The earliest next grant is T+6.
REQ-029 Outside BEAT: ram_en_o = 0, ram_we_o = 0, ram_addr_o = 0, ram_wdata_o = 0.
REQ-030 A request deasserted before grant is dropped with no side effect. Requests arriving during BEAT or RESP wait; they are never lost or granted early.
REQ-031 The beat counter wraps 3 -> exit. No beat index above 3 is ever driven.

Reset
REQ-032 While rst = 1, asynchronously:
- state = IDLE, beat = 0, last-granted pointer = port 1 (so port 0 wins the first tie);
- all outputs = 0, including gnt_o, rvalid_o, rdata_o and the ram_* outputs.
REQ-033 rst asserted mid-transaction aborts it with no rvalid. Beats already written stay in RAM. After release, the block restarts from IDLE.

Verification
REQ-034 Port 0 reads addr 0x100, RAM bytes 0x11/0x22/0x33/0x44 -> ram_addr 0x100..0x103, rvalid_o = 2'b01 at T+5, rdata_o = 0x44332211.
REQ-035 Port 1 writes 0xAABBCCDD to 0x200 with wstrb = 4'b0101 -> ram_we_o only on beats 0 and 2 (bytes 0xDD, 0xBB); rvalid_o = 2'b10 at T+5.
REQ-036 Both ports request continuously after reset with RR_EN = 1 -> grants alternate 0, 1, 0, 1, with 6 cycles between grants.
REQ-037 Same stimulus as REQ-036 with RR_EN = 0 -> port 0 is granted every time; port 1 is never granted.
REQ-038 rst pulsed during beat 2 of a write -> no rvalid; beats 0..1 are written and beats 2..3 are not. The next request is granted in the first cycle after release.
REQ-039 Port 1 request deasserted during port 0's BEAT -> it is never granted and the RAM sees no access for it.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter that serialises 32-bit word accesses onto a byte-wide RAM.
// Each granted access takes four byte beats, then a one-cycle completion pulse.
module ram_arbiter #(
    parameter int AW    = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [31:0]   wdata0_i,
    input  logic [31:0]   wdata1_i,
    input  logic [3:0]    wstrb0_i,
    input  logic [3:0]    wstrb1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [7:0]    ram_wdata_o,
    input  logic [7:0]    ram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [1:0]    beat_r;
    logic          last_r;
    logic          port_r;
    logic          we_r;
    logic [AW-3:0] addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    strb_r;
    logic [31:0]   word_r;
    logic [1:0]    gnt_s;
    logic          unused_s;

    assign unused_s = ^{addr0_i[1:0], addr1_i[1:0]};

    // Arbitration: grants only in IDLE and never while reset is applied.
    always_comb begin
        gnt_s = 2'b00;
        if (state_r == IDLE && !rst) begin
            case (req_i)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11: begin
                    if (RR_EN && !last_r) begin
                        gnt_s = 2'b10;
                    end else begin
                        gnt_s = 2'b01;
                    end
                end
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_nxt_s = BEAT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BEAT: begin
                if (beat_r == 2'd3) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BEAT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, request latch, beat counter and read-word assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            beat_r  <= 2'd0;
            last_r  <= 1'b1;
            port_r  <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {(AW-2){1'b0}};
            wdata_r <= 32'h0000_0000;
            strb_r  <= 4'h0;
            word_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (gnt_s != 2'b00) begin
                        port_r  <= gnt_s[1];
                        last_r  <= gnt_s[1];
                        we_r    <= gnt_s[1] ? we_i[1] : we_i[0];
                        addr_r  <= gnt_s[1] ? addr1_i[AW-1:2] : addr0_i[AW-1:2];
                        wdata_r <= gnt_s[1] ? wdata1_i : wdata0_i;
                        strb_r  <= gnt_s[1] ? wstrb1_i : wstrb0_i;
                        word_r  <= 32'h0000_0000;
                        beat_r  <= 2'd0;
                    end else begin
                        beat_r  <= 2'd0;
                    end
                end
                BEAT: begin
                    if (!we_r) begin
                        word_r[{beat_r, 3'b000} +: 8] <= ram_rdata_i;
                    end else begin
                        word_r <= word_r;
                    end
                    beat_r <= beat_r + 2'd1;
                end
                default: beat_r <= 2'd0;
            endcase
        end
    end

    // RAM port and completion outputs, decoded from the current state.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = {AW{1'b0}};
        ram_wdata_o = 8'h00;
        rvalid_o    = 2'b00;
        rdata_o     = 32'h0000_0000;
        if (state_r == BEAT) begin
            ram_addr_o = {addr_r, beat_r};
            if (!we_r) begin
                ram_en_o = 1'b1;
            end else if (strb_r[beat_r]) begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_wdata_o = wdata_r[{beat_r, 3'b000} +: 8];
            end else begin
                ram_en_o = 1'b0;
            end
        end else if (state_r == RESP) begin
            rvalid_o = port_r ? 2'b10 : 2'b01;
            rdata_o  = we_r ? 32'h0000_0000 : word_r;
        end else begin
            rvalid_o = 2'b00;
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance with a byte-pattern RAM
// model, plus a fixed-priority instance sharing the same request stimulus.
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;

    logic [1:0]  gnt, rvalid, gnt_fp, rvalid_fp;
    logic [31:0] rdata, rdata_fp, ram_addr, ram_addr_fp;
    logic        ram_en, ram_we, ram_en_fp, ram_we_fp;
    logic [7:0]  ram_wdata, ram_rdata, ram_wdata_fp;
    logic [2:0]  nib;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // RAM model: byte at offset k of any word reads as 0x11*(k+1).
    assign nib       = {1'b0, ram_addr[1:0]} + 3'd1;
    assign ram_rdata = {1'b0, nib, 1'b0, nib};

    ram_arbiter #(.AW(32), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .wstrb0_i(wstrb0), .wstrb1_i(wstrb1), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    ram_arbiter #(.AW(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .wstrb0_i(wstrb0), .wstrb1_i(wstrb1), .gnt_o(gnt_fp), .rvalid_o(rvalid_fp),
        .rdata_o(rdata_fp), .ram_en_o(ram_en_fp), .ram_we_o(ram_we_fp),
        .ram_addr_o(ram_addr_fp), .ram_wdata_o(ram_wdata_fp), .ram_rdata_i(8'h00)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; we = 2'b00;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        wstrb0 = 4'h0; wstrb1 = 4'h0;
        #2;
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        total++; if (rvalid !== 2'b00 || rdata !== 32'h0) begin bad++; $display("FAIL reset_resp got=%b/%h exp=00/0", rvalid, rdata); end
        total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== 42'h0) begin bad++; $display("FAIL reset_ram got=%b%b %h %h exp=0", ram_en, ram_we, ram_addr, ram_wdata); end
        step();
        req = 2'b00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_read();
        req = 2'b01; we = 2'b00; addr0 = 32'h0000_0100; wstrb0 = 4'h0;
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL read_gnt got=%b exp=01", gnt); end
        step();
        req = 2'b00;
        for (int b = 0; b < 4; b++) begin
            #1;
            total++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h100 + b) begin
                bad++; $display("FAIL read_beat%0d got=en%b we%b %h exp=en1 we0 %h", b, ram_en, ram_we, ram_addr, 32'h100 + b);
            end
            step();
        end
        #1;
        total++; if (rvalid !== 2'b01 || rdata !== 32'h4433_2211) begin bad++; $display("FAIL read_resp got=%b/%h exp=01/44332211", rvalid, rdata); end
        step();
        total++; if (rvalid !== 2'b00 || rdata !== 32'h0 || ram_en !== 1'b0) begin bad++; $display("FAIL read_after got=%b/%h/%b exp=00/0/0", rvalid, rdata, ram_en); end
    endtask

    task automatic test_write();
        logic [3:0] exp_we;
        logic [7:0] exp_byte [4];
        exp_we = 4'b0101;
        exp_byte[0] = 8'hDD; exp_byte[1] = 8'h00; exp_byte[2] = 8'hBB; exp_byte[3] = 8'h00;
        req = 2'b10; we = 2'b10; addr1 = 32'h0000_0200; wdata1 = 32'hAABB_CCDD; wstrb1 = 4'b0101;
        #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL write_gnt got=%b exp=10", gnt); end
        step();
        req = 2'b00;
        for (int b = 0; b < 4; b++) begin
            #1;
            total++; if (ram_we !== exp_we[b] || ram_en !== exp_we[b] || ram_wdata !== exp_byte[b] || ram_addr !== 32'h200 + b) begin
                bad++; $display("FAIL write_beat%0d got=en%b we%b %h %h exp=we%b %h %h", b, ram_en, ram_we, ram_addr, ram_wdata, exp_we[b], 32'h200 + b, exp_byte[b]);
            end
            step();
        end
        #1;
        total++; if (rvalid !== 2'b10 || rdata !== 32'h0) begin bad++; $display("FAIL write_resp got=%b/%h exp=10/0", rvalid, rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        do_reset();
        req = 2'b11; we = 2'b00; addr0 = 32'h100; addr1 = 32'h200;
        for (int g = 0; g < 4; g++) begin
            #1;
            total++; if (gnt !== exp_g[g]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", g, gnt, exp_g[g]); end
            total++; if (gnt_fp !== 2'b01) begin bad++; $display("FAIL fp_grant%0d got=%b exp=01", g, gnt_fp); end
            for (int c = 1; c <= 5; c++) begin
                step();
                #1;
                total++; if (gnt !== 2'b00 || gnt_fp !== 2'b00) begin bad++; $display("FAIL gap%0d_%0d got=%b/%b exp=00/00", g, c, gnt, gnt_fp); end
                if (c == 5) begin
                    total++; if (rvalid !== exp_g[g] || rvalid_fp !== 2'b01) begin bad++; $display("FAIL bb_rvalid%0d got=%b/%b exp=%b/01", g, rvalid, rvalid_fp, exp_g[g]); end
                end
            end
            step();
        end
        req = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 2'b10; we = 2'b10; addr1 = 32'h300; wdata1 = 32'hAABB_CCDD; wstrb1 = 4'hF;
        #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rm_gnt got=%b exp=10", gnt); end
        step();
        req = 2'b00;
        #1;
        total++; if (ram_we !== 1'b1 || ram_wdata !== 8'hDD || ram_addr !== 32'h300) begin bad++; $display("FAIL rm_beat0 got=%b %h %h exp=1 dd 300", ram_we, ram_wdata, ram_addr); end
        step();
        #1;
        total++; if (ram_we !== 1'b1 || ram_wdata !== 8'hCC || ram_addr !== 32'h301) begin bad++; $display("FAIL rm_beat1 got=%b %h %h exp=1 cc 301", ram_we, ram_wdata, ram_addr); end
        step();
        rst = 1'b1;
        req = 2'b01; we = 2'b00; addr0 = 32'h100;
        #1;
        total++; if (ram_we !== 1'b0 || ram_en !== 1'b0 || ram_addr !== 32'h0) begin bad++; $display("FAIL rm_beat2 got=%b%b %h exp=00 0", ram_en, ram_we, ram_addr); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (rvalid !== 2'b00 || ram_en !== 1'b0 || gnt !== 2'b00) begin bad++; $display("FAIL rm_hold%0d got=%b %b %b exp=00 0 00", c, rvalid, ram_en, gnt); end
        end
        rst = 1'b0;
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_regrant got=%b exp=01", gnt); end
        step();
        req = 2'b00;
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (c == 5) begin
                total++; if (rvalid !== 2'b01 || rdata !== 32'h4433_2211) begin bad++; $display("FAIL rm_resp got=%b/%h exp=01/44332211", rvalid, rdata); end
            end
            step();
        end
    endtask

    task automatic test_drop();
        req = 2'b01; we = 2'b00; addr0 = 32'h140; addr1 = 32'h3FC;
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL drop_gnt got=%b exp=01", gnt); end
        step();
        req = 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) req = 2'b00;
            #1;
            total++; if (gnt !== 2'b00 || ram_addr !== 32'h140 + b) begin bad++; $display("FAIL drop_beat%0d got=%b %h exp=00 %h", b, gnt, ram_addr, 32'h140 + b); end
            step();
        end
        #1;
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL drop_resp got=%b exp=01", rvalid); end
        for (int c = 0; c < 8; c++) begin
            step();
            total++; if (gnt !== 2'b00 || ram_en !== 1'b0 || rvalid !== 2'b00) begin bad++; $display("FAIL drop_idle%0d got=%b %b %b exp=00 0 00", c, gnt, ram_en, rvalid); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
